mem_bus_arbiter: RTL and testbench

Two-master, one-slave arbiter that shares the single-port data_memory between the CPU instruction-fetch port (read-only) and the data port (read/write). It adds Avalon-style waitrequest handshaking, configurable wait states and round-robin or fixed-priority selection. It sits between the CPU and data_memory in the test harness.

---
 rtl/mem_arb_pkg.sv | 6 +
 rtl/rr_arbiter_2.sv | 12 +
 rtl/mem_bus_arbiter.sv | 114 +++++++++++
 tb/tb_mem_bus_arbiter.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the two-master memory bus arbiter.
package mem_arb_pkg;
    typedef enum logic {IDLE, BUSY} arb_state_t;
    typedef enum logic {REQ_INSTR, REQ_DATA} req_id_t;
    localparam int WAIT_CNT_W = 4;
endpackage

// File: rtl/rr_arbiter_2.sv
// rr_arbiter_2: combinational two-way pick; req[0]=instr, req[1]=data.
module rr_arbiter_2 import mem_arb_pkg::*; (
    input  logic [1:0] req,
    input  req_id_t    last_grant,
    input  logic       fixed_priority,
    output req_id_t    grant
);
    // On conflict the data port wins unless it was the last one served in round-robin mode
    always_comb
        grant = (req == 2'b11) ? ((fixed_priority || last_grant == REQ_INSTR) ? REQ_DATA : REQ_INSTR)
                               : (req[1] ? REQ_DATA : REQ_INSTR);
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory port between fetch and data masters with waitrequest handshaking.
// Define ARB_STATS_EN to add grant/conflict statistics counters.
module mem_bus_arbiter import mem_arb_pkg::*; #(
    parameter int WAIT_STATES   = 0,
    parameter int DATA_PRIORITY = 0,
    parameter int ADDR_W        = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] instr_address,
    input  logic              instr_read,
    output logic              instr_waitrequest,
    output logic [31:0]       instr_readdata,
    input  logic [ADDR_W-1:0] data_address,
    input  logic              data_read,
    input  logic              data_write,
    input  logic [31:0]       data_writedata,
    output logic              data_waitrequest,
    output logic [31:0]       data_readdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       mem_writedata,
    input  logic [31:0]       mem_readdata
`ifdef ARB_STATS_EN
    ,
    output logic [31:0]       stat_instr_grants,
    output logic [31:0]       stat_data_grants,
    output logic [31:0]       stat_conflicts
`endif
);
    localparam logic [WAIT_CNT_W-1:0] WS = WAIT_CNT_W'(WAIT_STATES);

    arb_state_t            state;
    logic [WAIT_CNT_W-1:0] cnt;
    req_id_t               last_grant, winner, grant;
    logic                  op_write;
    logic [31:0]           instr_hold, data_hold;

    logic data_req, done, instr_done, data_done, grant_write;
    assign data_req    = data_read || data_write;
    assign done        = state == BUSY && cnt == '0;
    assign instr_done  = done && winner == REQ_INSTR;
    assign data_done   = done && winner == REQ_DATA;
    assign grant_write = grant == REQ_DATA && data_write;

    rr_arbiter_2 u_rr (
        .req           ({data_req, instr_read}),
        .last_grant    (last_grant),
        .fixed_priority(DATA_PRIORITY != 0),
        .grant         (grant)
    );

    assign instr_waitrequest = instr_read && !instr_done;
    assign data_waitrequest  = data_req && !data_done;
    assign instr_readdata    = instr_done ? mem_readdata : instr_hold;
    assign data_readdata     = (data_done && !op_write) ? mem_readdata : data_hold;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            cnt           <= '0;
            last_grant    <= REQ_INSTR;
            winner        <= REQ_INSTR;
            op_write      <= 1'b0;
            mem_read      <= 1'b0;
            mem_write     <= 1'b0;
            mem_address   <= '0;
            mem_writedata <= '0;
            instr_hold    <= '0;
            data_hold     <= '0;
        end else if (state == IDLE) begin
            if (instr_read || data_req) begin
                state       <= BUSY;
                cnt         <= WS;
                winner      <= grant;
                last_grant  <= grant;
                op_write    <= grant_write;
                mem_address <= (grant == REQ_DATA) ? data_address : instr_address;
                mem_read    <= !grant_write;
                // Strobe is registered, so with no wait states it must be raised on entry
                mem_write   <= grant_write && WS == '0;
                if (grant_write)
                    mem_writedata <= data_writedata;
            end
        end else begin
            cnt       <= (cnt != '0) ? cnt - 1'b1 : cnt;
            mem_write <= op_write && cnt == WAIT_CNT_W'(1);
            if (done) begin
                state    <= IDLE;
                mem_read <= 1'b0;
            end
            // A winner that abandoned its request does not get the response
            if (instr_done && instr_read)
                instr_hold <= mem_readdata;
            if (data_done && !op_write && data_req)
                data_hold <= mem_readdata;
        end
    end

`ifdef ARB_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_instr_grants <= '0;
            stat_data_grants  <= '0;
            stat_conflicts    <= '0;
        end else if (state == IDLE && (instr_read || data_req)) begin
            stat_instr_grants <= stat_instr_grants + 32'(grant == REQ_INSTR);
            stat_data_grants  <= stat_data_grants + 32'(grant == REQ_DATA);
            stat_conflicts    <= stat_conflicts + 32'(instr_read && data_req);
        end
    end
`endif
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed vector table plus multi-cycle sequences on three parameterisations.
module tb_mem_bus_arbiter;
    localparam int N = 3;
    localparam int WS[N] = '{0, 3, 2};
    localparam int DP[N] = '{0, 0, 1};

    logic clk = 1'b0, rst_n = 1'b0;
    logic instr_rd[N], data_rd[N], data_wr[N], instr_wait[N], data_wait[N], m_rd[N], m_wr[N];
    logic [31:0] instr_addr[N], data_addr[N], data_wd[N], instr_q[N], data_q[N];
    logic [31:0] m_addr[N], m_wd[N], m_rdata[N];
`ifdef ARB_STATS_EN
    logic [31:0] s_ig[N], s_dg[N], s_cf[N];
`endif
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    for (genvar i = 0; i < N; i++) begin : g_dut
        logic [31:0] mem [16];
        mem_bus_arbiter #(.WAIT_STATES(WS[i]), .DATA_PRIORITY(DP[i]), .ADDR_W(32)) u_dut (
            .clk(clk), .reset_n(rst_n),
            .instr_address(instr_addr[i]), .instr_read(instr_rd[i]),
            .instr_waitrequest(instr_wait[i]), .instr_readdata(instr_q[i]),
            .data_address(data_addr[i]), .data_read(data_rd[i]), .data_write(data_wr[i]),
            .data_writedata(data_wd[i]), .data_waitrequest(data_wait[i]), .data_readdata(data_q[i]),
            .mem_address(m_addr[i]), .mem_read(m_rd[i]), .mem_write(m_wr[i]),
            .mem_writedata(m_wd[i]), .mem_readdata(m_rdata[i])
`ifdef ARB_STATS_EN
            , .stat_instr_grants(s_ig[i]), .stat_data_grants(s_dg[i]), .stat_conflicts(s_cf[i])
`endif
        );
        assign m_rdata[i] = mem[m_addr[i][5:2]];
        always @(posedge clk or negedge rst_n)
            if (!rst_n) for (int j = 0; j < 16; j++) mem[j] <= 32'hA000_0000 + 32'(j);
            else if (m_wr[i]) mem[m_addr[i][5:2]] <= m_wd[i];
    end

    // req = {instr_read, data_read, data_write}; fl = {instr_wait, data_wait, mem_read, mem_write}
    typedef struct {
        logic [2:0]  req;
        logic [31:0] ia, da, wd;
        logic [3:0]  fl;
        logic [31:0] ma, mwd, ird, drd;
    } vec_t;
    vec_t v[14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic drive(input int k, input logic [2:0] req, input logic [31:0] ia, da, wd);
        instr_rd[k] = req[2]; data_rd[k] = req[1]; data_wr[k] = req[0];
        instr_addr[k] = ia; data_addr[k] = da; data_wd[k] = wd;
    endtask

`ifdef ARB_STATS_EN
    task automatic serve(input int k, input logic wi, input logic wdr);
        logic pi, pd;
        int n;
        pi = wi; pd = wdr; n = 0;
        drive(k, {pi, pd, 1'b0}, 32'h0, 32'h4, 32'h0);
        while ((pi || pd) && n < 20) begin
            @(negedge clk);
            if (pi && !instr_wait[k]) pi = 1'b0;
            if (pd && !data_wait[k]) pd = 1'b0;
            @(posedge clk); #1;
            drive(k, {pi, pd, 1'b0}, 32'h0, 32'h4, 32'h0);
            n++;
        end
        chk("serve within budget", 32'(n < 20), 32'd1);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic stall_ok, wr_seen;
        int dgrants;
        for (int k = 0; k < N; k++) drive(k, 3'b000, 32'h0, 32'h0, 32'h0);
        v[0]  = '{3'b100, 32'hBFC0_0000, 32'h0, 32'h0, 4'b1000, 32'h0, 32'h0, 32'h0, 32'h0};
        v[1]  = '{3'b100, 32'hBFC0_0000, 32'h0, 32'h0, 4'b0010, 32'hBFC0_0000, 32'h0, 32'hA000_0000, 32'h0};
        v[2]  = '{3'b000, 32'h0, 32'h0, 32'h0, 4'b0000, 32'hBFC0_0000, 32'h0, 32'hA000_0000, 32'h0};
        v[3]  = '{3'b110, 32'h8, 32'hC, 32'h0, 4'b1100, 32'hBFC0_0000, 32'h0, 32'hA000_0000, 32'h0};
        v[4]  = '{3'b110, 32'h8, 32'hC, 32'h0, 4'b1010, 32'hC, 32'h0, 32'hA000_0000, 32'hA000_0003};
        v[5]  = '{3'b110, 32'h8, 32'hC, 32'h0, 4'b1100, 32'hC, 32'h0, 32'hA000_0000, 32'hA000_0003};
        v[6]  = '{3'b110, 32'h8, 32'hC, 32'h0, 4'b0110, 32'h8, 32'h0, 32'hA000_0002, 32'hA000_0003};
        v[7]  = '{3'b110, 32'h8, 32'hC, 32'h0, 4'b1100, 32'h8, 32'h0, 32'hA000_0002, 32'hA000_0003};
        v[8]  = '{3'b110, 32'h8, 32'hC, 32'h0, 4'b1010, 32'hC, 32'h0, 32'hA000_0002, 32'hA000_0003};
        v[9]  = '{3'b011, 32'h0, 32'h10, 32'hDEAD_BEEF, 4'b0100, 32'hC, 32'h0, 32'hA000_0002, 32'hA000_0003};
        v[10] = '{3'b011, 32'h0, 32'h10, 32'hDEAD_BEEF, 4'b0001, 32'h10, 32'hDEAD_BEEF, 32'hA000_0002, 32'hA000_0003};
        v[11] = '{3'b010, 32'h0, 32'h10, 32'h0, 4'b0100, 32'h10, 32'hDEAD_BEEF, 32'hA000_0002, 32'hA000_0003};
        v[12] = '{3'b010, 32'h0, 32'h10, 32'h0, 4'b0010, 32'h10, 32'hDEAD_BEEF, 32'hA000_0002, 32'hDEAD_BEEF};
        v[13] = '{3'b000, 32'h0, 32'h0, 32'h0, 4'b0000, 32'h10, 32'hDEAD_BEEF, 32'hA000_0002, 32'hDEAD_BEEF};

        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset mem_read", 32'(m_rd[0]), 32'd0);
        chk("reset mem_write", 32'(m_wr[0]), 32'd0);
        chk("reset mem_address", m_addr[0], 32'h0);
        chk("reset instr_readdata", instr_q[0], 32'h0);
        chk("reset data_readdata", data_q[0], 32'h0);

        // WAIT_STATES=0, round-robin: fetch, D/I/D alternation, read+write as write, read-back
        for (int r = 0; r < 14; r++) begin
            @(posedge clk); #1;
            drive(0, v[r].req, v[r].ia, v[r].da, v[r].wd);
            @(negedge clk);
            chk($sformatf("v%0d instr_wait", r), 32'(instr_wait[0]), 32'(v[r].fl[3]));
            chk($sformatf("v%0d data_wait", r), 32'(data_wait[0]), 32'(v[r].fl[2]));
            chk($sformatf("v%0d mem_read", r), 32'(m_rd[0]), 32'(v[r].fl[1]));
            chk($sformatf("v%0d mem_write", r), 32'(m_wr[0]), 32'(v[r].fl[0]));
            chk($sformatf("v%0d mem_address", r), m_addr[0], v[r].ma);
            chk($sformatf("v%0d mem_writedata", r), m_wd[0], v[r].mwd);
            chk($sformatf("v%0d instr_readdata", r), instr_q[0], v[r].ird);
            chk($sformatf("v%0d data_readdata", r), data_q[0], v[r].drd);
        end

        // WAIT_STATES=3 write: completes in cycle 4 with a single mem_write pulse
        @(posedge clk); #1;
        drive(1, 3'b001, 32'h0, 32'h1000, 32'hDEAD_BEEF);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk($sformatf("ws3 data_wait c%0d", c), 32'(data_wait[1]), 32'(c < 4));
            chk($sformatf("ws3 mem_write c%0d", c), 32'(m_wr[1]), 32'(c == 4));
            if (c == 4) begin
                chk("ws3 mem_address", m_addr[1], 32'h1000);
                chk("ws3 mem_writedata", m_wd[1], 32'hDEAD_BEEF);
            end
            @(posedge clk); #1;
            if (c == 4) drive(1, 3'b000, 32'h0, 32'h0, 32'h0);
        end

        // DATA_PRIORITY=1: data wins every transaction, fetch stays stalled
        drive(2, 3'b110, 32'h0, 32'h4, 32'h0);
        stall_ok = 1'b1; dgrants = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (!instr_wait[2]) stall_ok = 1'b0;
            if (!data_wait[2]) dgrants++;
            @(posedge clk); #1;
        end
        drive(2, 3'b000, 32'h0, 32'h0, 32'h0);
        chk("dp1 instr stalled", 32'(stall_ok), 32'd1);
        chk("dp1 data grants", 32'(dgrants), 32'd3);

        // Reset in the middle of a WAIT_STATES=2 write aborts it
        @(posedge clk); #1;
        drive(2, 3'b001, 32'h0, 32'h8, 32'h1234_5678);
        @(negedge clk);
        chk("rst pre data_wait", 32'(data_wait[2]), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst busy mem_address", m_addr[2], 32'h8);
        #1 rst_n = 1'b0;
        #1;
        chk("rst async mem_write", 32'(m_wr[2]), 32'd0);
        chk("rst async mem_address", m_addr[2], 32'h0);
        chk("rst async mem_writedata", m_wd[2], 32'h0);
        chk("rst async mem_read", 32'(m_rd[2]), 32'd0);
        chk("rst async data_wait", 32'(data_wait[2]), 32'd1);
        drive(2, 3'b000, 32'h0, 32'h0, 32'h0);
        wr_seen = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (m_wr[2]) wr_seen = 1'b1;
            @(posedge clk); #1;
        end
        chk("rst no mem_write", 32'(wr_seen), 32'd0);
        drive(2, 3'b010, 32'h0, 32'h8, 32'h0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("post-rst data_wait c%0d", c), 32'(data_wait[2]), 32'(c < 3));
            if (c == 3) chk("post-rst data_readdata", data_q[2], 32'hA000_0002);
            @(posedge clk); #1;
        end
        drive(2, 3'b000, 32'h0, 32'h0, 32'h0);

`ifdef ARB_STATS_EN
        for (int t = 0; t < 3; t++) serve(0, 1'b1, 1'b1);
        for (int t = 0; t < 2; t++) serve(0, 1'b1, 1'b0);
        @(negedge clk);
        chk("stat conflicts", s_cf[0], 32'd3);
        chk("stat grants sum", s_ig[0] + s_dg[0], 32'd8);
        chk("stat instr grants", s_ig[0], 32'd5);
        chk("stat data grants", s_dg[0], 32'd3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
